mul_result_sequencer: RTL

//  Sequential control stage around the combinational Booth multiplier.
//  - Latches operands on a MUL issue and holds them on the multiplier inputs.
//  - Waits a fixed settle time, then captures the 64-bit product into internal Z registers.
//  - Writes the low and high words to the LO and HI registers over the shared 32-bit bus.
//  - Each bus write uses a request/grant handshake.

---
 rtl/mul_result_sequencer.sv | 80 ++++++++
 1 files changed

// File: rtl/mul_result_sequencer.sv
// mul_result_sequencer: holds operands on the Booth multiplier, captures the product and writes LO/HI over the shared bus.
// Optional ovf flag port enabled by defining MUL_OVF_FLAG_EN.
module mul_result_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] mul_x,
  output logic [WIDTH-1:0] mul_y,
  output logic             mul_en,
  input  logic [WIDTH-1:0] prod_lo,
  input  logic [WIDTH-1:0] prod_hi,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [WIDTH-1:0] bus_out,
  output logic             lo_wr,
  output logic             hi_wr,
  output logic             busy,
  output logic             done
`ifdef MUL_OVF_FLAG_EN
  , output logic           ovf
`endif
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_XFER_LO, S_XFER_HI, S_DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] zlo, zhi;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      cnt <= '0;
      mul_x <= '0;
      mul_y <= '0;
      zlo <= '0;
      zhi <= '0;
    end else begin
      state <= nxt;
      cnt <= state == S_SETTLE ? cnt + 1'b1 : '0;
      if (state == S_IDLE && start) begin
        mul_x <= x_in;
        mul_y <= y_in;
      end
      if (state == S_CAPTURE) begin
        zlo <= prod_lo;
        zhi <= prod_hi;
      end
    end
  end
`ifdef MUL_OVF_FLAG_EN
  // Evaluated on the words being captured, so it tracks zlo/zhi exactly.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) ovf <= 1'b0;
    else if (state == S_CAPTURE) ovf <= prod_hi != {WIDTH{prod_lo[WIDTH-1]}};
  end
`endif
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = SETTLE_CYCLES == 0 ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  if (cnt == LAST) nxt = S_CAPTURE;
      S_CAPTURE: nxt = S_XFER_LO;
      S_XFER_LO: if (bus_gnt) nxt = S_XFER_HI;
      S_XFER_HI: if (bus_gnt) nxt = S_DONE;
      default:   nxt = S_IDLE;
    endcase
    mul_en = state == S_SETTLE || state == S_CAPTURE;
    bus_req = state == S_XFER_LO || state == S_XFER_HI;
    lo_wr = state == S_XFER_LO && bus_gnt;
    hi_wr = state == S_XFER_HI && bus_gnt;
    bus_out = lo_wr ? zlo : hi_wr ? zhi : '0;
    busy = state != S_IDLE;
    done = state == S_DONE;
  end
endmodule
